// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with FWFT byte FIFO and cts flow control
// Oversampled receive FSM feeds a small FIFO presented as a valid/ready byte stream.
module uart_rx_fifo #(
   parameter int CLK_FREQ   = 12000000,
   parameter int UART_FREQ  = 115200,
   parameter int FIFO_DEPTH = 8,
   parameter int CTS_MARGIN = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       cts,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int DIV = CLK_FREQ / UART_FREQ;
   localparam int CW  = $clog2(DIV);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] BIT_LOAD  = CW'(DIV - 1);
   localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CTS_LIMIT = (AW + 1)'(FIFO_DEPTH - CTS_MARGIN - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t          state;
   logic [1:0]      sync;
   logic            rx_s;
   logic            rx_prev;
   logic [CW-1:0]   baud;
   logic [2:0]      idx;
   logic [7:0]      shreg;
   logic            tick;
   logic            push;
   logic            stop_bad;

   assign rx_s     = sync[1];
   assign tick     = (baud == '0);
   assign push     = (state == STOP) && tick && rx_s;
   assign stop_bad = (state == STOP) && tick && !rx_s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync      <= 2'b11;
         rx_prev   <= 1'b1;
         state     <= IDLE;
         baud      <= '0;
         idx       <= '0;
         shreg     <= '0;
         frame_err <= 1'b0;
      end else begin
         sync      <= {sync[0], rx};
         rx_prev   <= rx_s;
         frame_err <= stop_bad;
         case (state)
            IDLE: begin
               if (rx_prev && !rx_s) begin
                  baud  <= HALF_LOAD;
                  state <= START;
               end
            end
            START: begin
               if (!tick) begin
                  baud <= baud - 1'b1;
               end else if (!rx_s) begin
                  baud  <= BIT_LOAD;
                  idx   <= '0;
                  state <= DATA;
               end else begin
                  state <= IDLE;
               end
            end
            DATA: begin
               if (!tick) begin
                  baud <= baud - 1'b1;
               end else begin
                  shreg[idx] <= rx_s;
                  baud       <= BIT_LOAD;
                  idx        <= idx + 1'b1;
                  if (idx == 3'd7) state <= STOP;
               end
            end
            STOP: begin
               if (!tick) baud <= baud - 1'b1;
               else       state <= rx_s ? IDLE : BREAK;
            end
            BREAK: begin
               // Hold here until the line idles so a stuck-low rx yields one error only.
               if (rx_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   count;
   logic [AW:0]   count_next;
   logic          full;
   logic          pop;
   logic          wr;

   assign valid = (count != '0);
   assign full  = (count == FULL_CNT);
   assign pop   = valid && ready;
   assign wr    = push && (!full || pop);
   assign data  = valid ? mem[rptr] : 8'h00;

   always_comb begin
      count_next = count;
      case ({wr, pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= shreg;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         cts     <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (wr)  wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         count   <= count_next;
         cts     <= (count_next <= CTS_LIMIT);
         overrun <= push && full && !pop;
      end
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial front end for the dbgu32 debug unit.
- Oversamples the host's rx line and decodes 8N1 frames.
- Buffers received bytes in a small first-word-fall-through FIFO and presents them on a valid/ready byte stream to the command parser.
- Drives cts so the host pauses before the buffer overflows during back-to-back command and payload bursts.

Parameters:
- CLK_FREQ, 12000000: system clock frequency in Hz.
- UART_FREQ, 115200: baud rate. DIV = CLK_FREQ/UART_FREQ, floored integer; DIV must be at least 8.
- FIFO_DEPTH, 8: byte entries. Must be a power of two, at least 4.
- CTS_MARGIN, 2: free entries reserved for bytes already in flight when cts drops.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  serial input from host, asynchronous, idle high.
- cts  out  1  1 = host may transmit.
- data  out  8  byte at the FIFO head.
- valid  out  1  FIFO non-empty; data is meaningful.
- ready  in  1  consumer accepts the head byte when valid && ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while FIFO full and not popping.

Behaviour:
- Reset:
  - Synchroniser flops = 1; state IDLE; bit and baud counters = 0.
  - FIFO empty: valid = 0, data = 0x00.
  - cts = 0, frame_err = 0, overrun = 0.
  - cts rises on the first clock after reset is released.
  - Reset mid-frame abandons the partial byte and empties the FIFO.
- Synchroniser: rx passes through 2 flops, giving rx_s. All decoding uses rx_s. Total latency 2 cycles.
- Receive FSM:
  - IDLE: a 1→0 transition on rx_s loads the baud counter with DIV/2−1 and goes to START.
  - START: when the counter reaches 0, sample rx_s.
    - 0: reload DIV−1, bit index = 0, go to DATA.
    - 1: glitch; return to IDLE, no error.
  - DATA: every DIV cycles sample rx_s into shift register bit[index], LSB first. After index 7, reload DIV−1 and go to STOP.
  - STOP: after DIV cycles sample rx_s.
    - 1: push the byte; go to IDLE.
    - 0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rx_s = 1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Push timing: the push happens in the cycle of the stop-bit sample. valid is high and data is correct on the next cycle (empty-FIFO case).
- FIFO:
  - Storage: pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
  - Pop: occurs when valid && ready. data always shows the head entry (first-word fall-through).
  - Full with push and pop in the same cycle: both succeed; count unchanged.
  - Full with push and no pop: the byte is dropped, overrun pulses, and stored contents are untouched.
  - Empty with push and pop in the same cycle: impossible, since valid = 0.
- cts: registered, = (count_next <= FIFO_DEPTH − CTS_MARGIN − 1).
  - It falls on the cycle after the entry that leaves only CTS_MARGIN free.
  - It rises one cycle after a pop restores margin.
- frame_err and overrun never pulse in the same cycle.

Test Plan (CLK_FREQ=12000000, UART_FREQ=115200 → DIV=104; FIFO_DEPTH=8, CTS_MARGIN=2):
1. Single frame 0xA5 on rx, ready=1 → exactly one valid beat with data=0xA5, about 9.5×104 cycles plus 3 after the start edge; no error pulses.
2. Back-to-back frames 0x01 0x00 0x00 0x02 0x00 0x05 (no idle gap), ready=1 → six beats in that order; cts stays 1; no error pulses.
3. ready=0, frames 0x10..0x18 → cts drops the cycle after 0x15 is stored. 0x18 gives an overrun pulse. With ready=1 afterwards, the pops read 0x10..0x17, then valid = 0, and cts returns to 1.
4. Frame 0x3C with stop bit held low for 3 bit times → frame_err pulses once; no push. The next frame 0x42 after rx returns high is received correctly.
5. rx low glitch of 30 cycles (< DIV/2) → no push, no error, FSM back in IDLE. The following frame 0x7E is received correctly.
6. Assert reset mid-way through frame 0x55 with 2 bytes queued → valid=0 and cts=0 during reset, FIFO empty. After release, frame 0x99 yields a single beat 0x99.
